// File: rtl/commit_check_sched_if.sv
// Bundle of commit-checker signals: HDL-side record stream, model-side record stream,
// and the comparison/status outputs.
interface commit_check_sched_if #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             dut_valid;
  logic [191:0]     dut_rec;
  logic             dut_ready;
  logic             mdl_valid;
  logic [191:0]     mdl_rec;
  logic             mdl_ready;
  logic             cmp_valid;
  logic [5:0]       cmp_mask;
  logic [31:0]      cmp_pc;
  logic [CNT_W-1:0] checked_cnt;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [PTR_W:0]   pending;
  logic             halted;

  modport master (
    output dut_valid, dut_rec, mdl_valid, mdl_rec,
    input  dut_ready, mdl_ready, cmp_valid, cmp_mask, cmp_pc,
           checked_cnt, mismatch_cnt, pending, halted
  );

  modport slave (
    input  dut_valid, dut_rec, mdl_valid, mdl_rec,
    output dut_ready, mdl_ready, cmp_valid, cmp_mask, cmp_pc,
           checked_cnt, mismatch_cnt, pending, halted
  );
endinterface

// File: rtl/commit_check_sched.sv
// Buffers HDL commit records in a FIFO and compares each, in order, against the
// reference-model record; reports per-field mismatch masks and saturating counters.
module commit_check_sched #(
  parameter int DEPTH            = 8,
  parameter int CNT_W            = 32,
  parameter int STOP_ON_MISMATCH = 1
) (
  input logic                 clk,
  input logic                 reset,
  commit_check_sched_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   OCC_ONE = 1;
  localparam logic [PTR_W:0]   OCC_FULL = DEPTH[PTR_W:0];
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  logic [191:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  state_t           state_q;
  logic             halted_q;
  logic             cmp_valid_q;
  logic [5:0]       cmp_mask_q;
  logic [31:0]      cmp_pc_q;
  logic [CNT_W-1:0] checked_q, mismatch_q;

  logic         push, pop;
  logic         dut_ready_d, mdl_ready_d;
  logic [191:0] head;
  logic [5:0]   mask_d;

  // Readiness depends only on registered state, never on the same-cycle valids.
  assign dut_ready_d = (count_q != OCC_FULL);
  assign mdl_ready_d = (state_q == ST_RUN) && (count_q != '0);
  assign push        = bus.dut_valid && dut_ready_d;
  assign pop         = bus.mdl_valid && mdl_ready_d;
  assign head        = mem_q[rd_ptr_q];

  // Field gi occupies record bits [32*gi +: 32]; b_address is field 0, pc is field 5.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_field_cmp
      assign mask_d[gi] = (head[gi*32 +: 32] != bus.mdl_rec[gi*32 +: 32]);
    end
  endgenerate

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + OCC_ONE;
    else if (!push && pop) count_d = count_q - OCC_ONE;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.dut_rec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_RUN;
      halted_q    <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_mask_q  <= '0;
      cmp_pc_q    <= '0;
      checked_q   <= '0;
      mismatch_q  <= '0;
    end else begin
      cmp_valid_q <= 1'b0;
      count_q     <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case (state_q)
        ST_RUN: begin
          if (pop) begin
            cmp_valid_q <= 1'b1;
            cmp_mask_q  <= mask_d;
            cmp_pc_q    <= head[191:160];
            if (checked_q != {CNT_W{1'b1}}) checked_q <= checked_q + CNT_ONE;
            if (mask_d != '0) begin
              if (mismatch_q != {CNT_W{1'b1}}) mismatch_q <= mismatch_q + CNT_ONE;
              if (STOP_ON_MISMATCH != 0) begin
                state_q  <= ST_HALT;
                halted_q <= 1'b1;
              end
            end
          end
        end
        ST_HALT: begin
          state_q  <= ST_HALT;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dut_ready    = dut_ready_d;
  assign bus.mdl_ready    = mdl_ready_d;
  assign bus.cmp_valid    = cmp_valid_q;
  assign bus.cmp_mask     = cmp_mask_q;
  assign bus.cmp_pc       = cmp_pc_q;
  assign bus.checked_cnt  = checked_q;
  assign bus.mismatch_cnt = mismatch_q;
  assign bus.pending      = count_q;
  assign bus.halted       = halted_q;
endmodule

// File: tb/tb_commit_check_sched.sv
// Randomized and directed bench for commit_check_sched: a STOP=1 instance and a STOP=0
// instance with narrow counters, both checked against a queue-based reference model.
module tb_commit_check_sched;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   sel = 1'b0;   // 0: halting instance, 1: free-running instance (4-bit counters)

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  commit_check_sched_if #(.DEPTH(DEPTH), .CNT_W(32)) if_a ();
  commit_check_sched_if #(.DEPTH(DEPTH), .CNT_W(4))  if_b ();

  commit_check_sched #(.DEPTH(DEPTH), .CNT_W(32), .STOP_ON_MISMATCH(1)) u_halt (
    .clk(clk), .reset(reset), .bus(if_a.slave));
  commit_check_sched #(.DEPTH(DEPTH), .CNT_W(4), .STOP_ON_MISMATCH(0)) u_run (
    .clk(clk), .reset(reset), .bus(if_b.slave));

  logic        o_dut_ready, o_mdl_ready, o_cmp_valid, o_halted;
  logic [5:0]  o_cmp_mask;
  logic [31:0] o_cmp_pc;
  logic [63:0] o_checked, o_mismatch;
  logic [63:0] o_pending;

  always_comb begin
    if (sel) begin
      o_dut_ready = if_b.dut_ready;   o_mdl_ready = if_b.mdl_ready;
      o_cmp_valid = if_b.cmp_valid;   o_halted    = if_b.halted;
      o_cmp_mask  = if_b.cmp_mask;    o_cmp_pc    = if_b.cmp_pc;
      o_checked   = 64'(if_b.checked_cnt);
      o_mismatch  = 64'(if_b.mismatch_cnt);
      o_pending   = 64'(if_b.pending);
    end else begin
      o_dut_ready = if_a.dut_ready;   o_mdl_ready = if_a.mdl_ready;
      o_cmp_valid = if_a.cmp_valid;   o_halted    = if_a.halted;
      o_cmp_mask  = if_a.cmp_mask;    o_cmp_pc    = if_a.cmp_pc;
      o_checked   = 64'(if_a.checked_cnt);
      o_mismatch  = 64'(if_a.mismatch_cnt);
      o_pending   = 64'(if_a.pending);
    end
  end

  // Reference model: an ordered queue of HDL records plus the expected result registers.
  logic [191:0]    mq[$];
  longint unsigned m_chk, m_mis;
  bit              m_halt, m_cv;
  logic [5:0]      m_mask;
  logic [31:0]     m_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [191:0] mk(input logic [31:0] pc, rs, rt, rd, j, b);
    return {pc, rs, rt, rd, j, b};
  endfunction

  function automatic logic [191:0] rnd_rec();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_chk = 0; m_mis = 0; m_halt = 0; m_cv = 0; m_mask = '0; m_pc = '0;
  endtask

  task automatic drive(input bit dv, input logic [191:0] drec, input bit mv, input logic [191:0] mrec);
    if_a.dut_valid = sel ? 1'b0 : dv;  if_a.dut_rec = drec;
    if_a.mdl_valid = sel ? 1'b0 : mv;  if_a.mdl_rec = mrec;
    if_b.dut_valid = sel ? dv : 1'b0;  if_b.dut_rec = drec;
    if_b.mdl_valid = sel ? mv : 1'b0;  if_b.mdl_rec = mrec;
  endtask

  // One clock cycle: drive, check readiness mid-cycle, advance model at the edge, check results.
  task automatic step(input bit dv, input logic [191:0] drec, input bit mv, input logic [191:0] mrec);
    bit stop_mode;
    bit push, pop;
    logic [191:0] head;
    longint unsigned cmax;
    stop_mode = !sel;
    cmax = sel ? 64'd15 : 64'hFFFF_FFFF;
    drive(dv, drec, mv, mrec);
    #3;
    check("dut_ready", 64'(o_dut_ready), 64'(mq.size() != DEPTH));
    check("mdl_ready", 64'(o_mdl_ready), 64'(!m_halt && mq.size() != 0));
    push = dv && (mq.size() != DEPTH);
    pop  = mv && !m_halt && (mq.size() != 0);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      m_cv = 1'b0;
      if (pop) begin
        head = mq.pop_front();
        for (int f = 0; f < 6; f++) m_mask[f] = (head[f*32 +: 32] != mrec[f*32 +: 32]);
        m_cv = 1'b1;
        m_pc = head[191:160];
        if (m_chk != cmax) m_chk++;
        if (m_mask != 0) begin
          if (m_mis != cmax) m_mis++;
          if (stop_mode) m_halt = 1'b1;
        end
      end
      if (push) mq.push_back(drec);
    end
    #1;
    check("cmp_valid", 64'(o_cmp_valid), 64'(m_cv));
    check("cmp_mask", 64'(o_cmp_mask), 64'(m_mask));
    check("cmp_pc", 64'(o_cmp_pc), 64'(m_pc));
    check("checked_cnt", o_checked, m_chk);
    check("mismatch_cnt", o_mismatch, m_mis);
    check("pending", o_pending, 64'(mq.size()));
    check("halted", 64'(o_halted), 64'(m_halt));
    if (m_cv) $display("txn inst=%0d pc=%h mask=%b checked=%0d", sel, m_pc, m_mask, m_chk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, '0, 1'b0, '0);
    reset = 1'b0;
  endtask

  function automatic logic [191:0] model_guess(input int err_pct);
    logic [191:0] r;
    int f;
    r = (mq.size() != 0) ? mq[0] : rnd_rec();
    if ($urandom_range(0, 99) < err_pct) begin
      f = $urandom_range(0, 5);
      r[f*32 +: 32] = r[f*32 +: 32] ^ 32'($urandom_range(1, 255));
    end
    return r;
  endfunction

  task automatic random_run(input int cycles, input int err_pct, input int rst_pct);
    for (int c = 0; c < cycles; c++) begin
      if ($urandom_range(0, 999) < rst_pct * 10 || (m_halt && $urandom_range(0, 29) == 0))
        do_reset();
      else
        step(1'($urandom_range(0, 99) < 55), rnd_rec(), 1'($urandom_range(0, 99) < 50),
             model_guess(err_pct));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [191:0] r1, r;
    drive(1'b0, '0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_pending", o_pending, 64'd0);
    check("rst_cmp_valid", 64'(o_cmp_valid), 64'd0);
    check("rst_checked", o_checked, 64'd0);
    reset = 1'b0;

    // T1: identical record
    r1 = mk(32'h0040_0000, 32'h11, 32'h22, 32'h33, 32'h44, 32'h55);
    step(1'b1, r1, 1'b0, '0);
    step(1'b0, '0, 1'b1, r1);
    check("t1_cmp_valid", 64'(o_cmp_valid), 64'd1);
    check("t1_mask", 64'(o_cmp_mask), 64'd0);
    check("t1_pc", 64'(o_cmp_pc), 64'h0040_0000);
    check("t1_checked", o_checked, 64'd1);
    step(1'b0, '0, 1'b0, '0);
    check("t1_pulse", 64'(o_cmp_valid), 64'd0);

    // T2: fill, overflow attempt, simultaneous pop+push while full, drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b1, mk(32'h1000 + 32'(i*4), 32'(i), 0, 0, 0, 0), 1'b0, '0);
    check("t2_full", o_pending, 64'd8);
    check("t2_ready", 64'(o_dut_ready), 64'd0);
    step(1'b1, mk(32'hDEAD, 0, 0, 0, 0, 0), 1'b0, '0);
    check("t2_ignored", o_pending, 64'd8);
    step(1'b1, mk(32'hBEEF, 0, 0, 0, 0, 0), 1'b1, mq[0]);
    check("t2_popfull", o_pending, 64'd7);
    step(1'b1, mk(32'h2000, 0, 0, 0, 0, 0), 1'b1, mq[0]);
    check("t2_pushpop", o_pending, 64'd7);
    while (mq.size() != 0) step(1'b0, '0, 1'b1, mq[0]);
    check("t2_drained", o_mismatch, 64'd0);

    // T5: push and model valid in same cycle on an empty FIFO
    r = mk(32'h3000, 1, 2, 3, 4, 5);
    step(1'b1, r, 1'b1, r);
    check("t5_no_cmp", 64'(o_cmp_valid), 64'd0);
    step(1'b0, '0, 1'b1, r);
    check("t5_cmp", 64'(o_cmp_valid), 64'd1);

    // T3: rd_value mismatch halts the STOP=1 instance
    step(1'b1, mk(32'h4000, 0, 0, 32'h5, 0, 0), 1'b0, '0);
    step(1'b0, '0, 1'b1, mk(32'h4000, 0, 0, 32'h6, 0, 0));
    check("t3_mask", 64'(o_cmp_mask), 64'b000100);
    check("t3_halted", 64'(o_halted), 64'd1);
    for (int i = 0; i < 5; i++) step(1'b1, rnd_rec(), 1'b1, rnd_rec());
    check("t3_pending", o_pending, 64'd5);
    check("t3_mdl_ready", 64'(o_mdl_ready), 64'd0);

    // T6: reset while halted with records pending
    do_reset();
    check("t6_pending", o_pending, 64'd0);
    check("t6_halted", 64'(o_halted), 64'd0);
    check("t6_mismatch", o_mismatch, 64'd0);

    random_run(600, 8, 1);

    // Switch to the free-running instance
    do_reset();
    sel = 1'b1;
    do_reset();

    // T4: j/b mismatch on record 2 only
    for (int i = 0; i < 3; i++) step(1'b1, mk(32'h5000 + 32'(i), 0, 0, 0, 32'h70, 32'h80), 1'b0, '0);
    step(1'b0, '0, 1'b1, mq[0]);
    check("t4_rec1", 64'(o_cmp_mask), 64'd0);
    r = mq[0];
    r[63:0] = {32'h71, 32'h81};
    step(1'b0, '0, 1'b1, r);
    check("t4_rec2", 64'(o_cmp_mask), 64'b000011);
    step(1'b0, '0, 1'b1, mq[0]);
    check("t4_rec3", 64'(o_cmp_mask), 64'd0);
    check("t4_checked", o_checked, 64'd3);
    check("t4_mismatch", o_mismatch, 64'd1);
    check("t4_halted", 64'(o_halted), 64'd0);

    random_run(1500, 30, 0);
    check("sat_checked", o_checked, 64'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
